// File: rtl/pipe_buf_pkg.sv
// Shared constants for the credit-buffered pipeline output and its wrapper.
// Holds the legal FIFO depth range and the credit/occupancy counter width.
package pipe_buf_pkg;

   localparam int DEPTH_MIN = 2;
   localparam int DEPTH_MAX = 16;

   // Width needed to hold any value 0..depth inclusive.
   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy counter.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo
   import pipe_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_WIDTH-1:0]         wdata,
   output logic [DATA_WIDTH-1:0]         rdata,
   output logic [credit_w(DEPTH)-1:0]    count,
   output logic                          full,
   output logic                          empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = credit_w(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Storage is intentionally left out of reset; rdata is meaningless while empty.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)
            rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pipe_out_credit_buffer.sv
// Credit-based output buffer for a stitched pipeline: the producer spends a credit per
// issue, the result lands in a FIFO, and the credit returns when downstream pops it.
module pipe_out_credit_buffer
   import pipe_buf_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          issue,
   output logic                          can_issue,
   input  logic                          pipe_valid,
   input  logic [DATA_WIDTH-1:0]         pipe_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic                          err_underflow_credit,
   output logic                          err_overflow
);

   localparam int CW = credit_w(DEPTH);

   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("pipe_out_credit_buffer: DEPTH out of range");
   end

   logic [CW-1:0] credits;
   logic          full;
   logic          empty;
   logic          pop;
   logic          issue_ok;

   assign can_issue = (credits != '0);
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   assign issue_ok  = issue && can_issue;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (pipe_valid),
      .pop   (pop),
      .wdata (pipe_data),
      .rdata (out_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Credits saturate at DEPTH so an illegal extra push cannot wrap the counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits              <= CW'(DEPTH);
         err_underflow_credit <= 1'b0;
         err_overflow         <= 1'b0;
      end else begin
         if (issue_ok && !pop)
            credits <= credits - 1'b1;
         else if (!issue_ok && pop && credits != CW'(DEPTH))
            credits <= credits + 1'b1;
         if (issue && !can_issue)
            err_underflow_credit <= 1'b1;
         if (pipe_valid && full && !pop)
            err_overflow <= 1'b1;
      end
   end

   a_credit_range: assert property (@(posedge clk) disable iff (rst) credits <= CW'(DEPTH));

endmodule
